// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - judges each light window as hit or miss, counts wrong presses, tracks lives
module hit_judge #(
  parameter int LIVES = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       enable,
  input  logic       use_lives,
  input  logic       light_new,
  input  logic [3:0] light_pos,
  input  logic       light_off,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [5:0] score,
  output logic [5:0] misses,
  output logic [5:0] wrong,
  output logic [1:0] lives_left,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       out_of_lives
);

  typedef enum logic [1:0] {IDLE, ARMED, JUDGED, DONE} state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t     state_q, state_d;
  logic [3:0] target_q, target_d;
  logic [5:0] score_q, score_d;
  logic [5:0] misses_q, misses_d;
  logic [5:0] wrong_q, wrong_d;
  logic [1:0] lives_q, lives_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       ool_q, ool_d;
  logic       key_hit;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  assign key_hit = key_valid && (key == target_q);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    score_d  = score_q;
    misses_d = misses_q;
    wrong_d  = wrong_q;
    lives_d  = lives_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    if (start) begin
      state_d  = IDLE;
      target_d = 4'd0;
      score_d  = 6'd0;
      misses_d = 6'd0;
      wrong_d  = 6'd0;
      lives_d  = LIVES_INIT;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (key_valid) wrong_d = sat_inc(wrong_q);
          if (light_new) begin
            state_d  = ARMED;
            target_d = light_pos;
          end
        end
        ARMED: begin
          if (key_hit) begin
            score_d = sat_inc(score_q);
            hit_d   = 1'b1;
          end else if (key_valid) begin
            wrong_d = sat_inc(wrong_q);
          end
          if (light_new) begin
            target_d = light_pos;
          end else if (light_off) begin
            state_d = IDLE;
          end else if (key_hit) begin
            state_d = JUDGED;
          end
          // A window closing unhit is a miss; running out of lives overrides the next state.
          if (!key_hit && (light_new || light_off)) begin
            misses_d = sat_inc(misses_q);
            miss_d   = 1'b1;
            if (use_lives && lives_q != 2'd0) begin
              lives_d = lives_q - 2'd1;
              if (lives_q == 2'd1) state_d = DONE;
            end
          end
        end
        JUDGED: begin
          if (light_new) begin
            state_d  = ARMED;
            target_d = light_pos;
          end else if (light_off) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
    ool_d = (state_d == DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      target_q <= 4'd0;
      score_q  <= 6'd0;
      misses_q <= 6'd0;
      wrong_q  <= 6'd0;
      lives_q  <= LIVES_INIT;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      ool_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      wrong_q  <= wrong_d;
      lives_q  <= lives_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      ool_q    <= ool_d;
    end
  end

  assign score        = score_q;
  assign misses       = misses_q;
  assign wrong        = wrong_q;
  assign lives_left   = lives_q;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign out_of_lives = ool_q;

endmodule

// File: tb/tb_hit_judge.sv
// tb/tb_hit_judge.sv - directed scenarios plus randomized run against a window-level scoring model
module tb_hit_judge;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b1;
  logic       use_lives = 1'b0;
  logic       light_new = 1'b0;
  logic [3:0] light_pos = 4'd0;
  logic       light_off = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic [5:0] score, misses, wrong;
  logic [1:0] lives_left;
  logic       hit_pulse, miss_pulse, out_of_lives;
  logic [22:0] obs;

  int checks = 0;
  int failures = 0;

  hit_judge dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .enable(enable),
    .use_lives(use_lives), .light_new(light_new), .light_pos(light_pos),
    .light_off(light_off), .key_valid(key_valid), .key(key),
    .score(score), .misses(misses), .wrong(wrong), .lives_left(lives_left),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .out_of_lives(out_of_lives)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  assign obs = {score, misses, wrong, lives_left, hit_pulse, miss_pulse, out_of_lives};

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    start = 1'b0; light_new = 1'b0; light_off = 1'b0; key_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #5 reset = 1'b1;
    tick();
    checks++;
    if (obs !== {6'd0, 6'd0, 6'd0, 2'd3, 3'b000}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs, {6'd0, 6'd0, 6'd0, 2'd3, 3'b000});
    end
  endtask

  task automatic test_hit_late_key();
    do_start();
    light_new = 1'b1; light_pos = 4'd4; tick();
    tick();
    key_valid = 1'b1; key = 4'd4; tick();
    checks++;
    if (obs !== {6'd1, 6'd0, 6'd0, 2'd3, 3'b100}) begin
      failures++; $display("FAIL late_first_hit got=%h exp=%h", obs, {6'd1, 6'd0, 6'd0, 2'd3, 3'b100});
    end
    key_valid = 1'b1; key = 4'd4; tick();
    checks++;
    if (obs !== {6'd1, 6'd0, 6'd0, 2'd3, 3'b000}) begin
      failures++; $display("FAIL late_second_key got=%h exp=%h", obs, {6'd1, 6'd0, 6'd0, 2'd3, 3'b000});
    end
    light_off = 1'b1; tick();
    checks++;
    if (obs !== {6'd1, 6'd0, 6'd0, 2'd3, 3'b000}) begin
      failures++; $display("FAIL late_light_off got=%h exp=%h", obs, {6'd1, 6'd0, 6'd0, 2'd3, 3'b000});
    end
  endtask

  task automatic test_wrong_then_right();
    do_start();
    light_new = 1'b1; light_pos = 4'd2; tick();
    key_valid = 1'b1; key = 4'd7; tick();
    checks++;
    if (obs !== {6'd0, 6'd0, 6'd1, 2'd3, 3'b000}) begin
      failures++; $display("FAIL wr_wrong got=%h exp=%h", obs, {6'd0, 6'd0, 6'd1, 2'd3, 3'b000});
    end
    key_valid = 1'b1; key = 4'd2; tick();
    checks++;
    if (obs !== {6'd1, 6'd0, 6'd1, 2'd3, 3'b100}) begin
      failures++; $display("FAIL wr_right got=%h exp=%h", obs, {6'd1, 6'd0, 6'd1, 2'd3, 3'b100});
    end
  endtask

  task automatic test_lives();
    logic [22:0] exp;
    use_lives = 1'b1;
    do_start();
    for (int w = 1; w <= 3; w++) begin
      light_new = 1'b1; light_pos = 4'(w); tick();
      light_off = 1'b1; tick();
      exp = {6'd0, 6'(w), 6'd0, 2'(3 - w), 1'b0, 1'b1, (w == 3)};
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL lives_window%0d got=%h exp=%h", w, obs, exp);
      end
    end
    light_new = 1'b1; light_pos = 4'd5; key_valid = 1'b1; key = 4'd1; tick();
    light_off = 1'b1; tick();
    checks++;
    if (obs !== {6'd0, 6'd3, 6'd0, 2'd0, 3'b001}) begin
      failures++; $display("FAIL lives_done_hold got=%h exp=%h", obs, {6'd0, 6'd3, 6'd0, 2'd0, 3'b001});
    end
    do_start();
    checks++;
    if (obs !== {6'd0, 6'd0, 6'd0, 2'd3, 3'b000}) begin
      failures++; $display("FAIL lives_restart got=%h exp=%h", obs, {6'd0, 6'd0, 6'd0, 2'd3, 3'b000});
    end
    use_lives = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_start();
    light_new = 1'b1; light_pos = 4'd5; tick();
    key_valid = 1'b1; key = 4'd5; light_off = 1'b1; tick();
    checks++;
    if (obs !== {6'd1, 6'd0, 6'd0, 2'd3, 3'b100}) begin
      failures++; $display("FAIL sim_hit_off got=%h exp=%h", obs, {6'd1, 6'd0, 6'd0, 2'd3, 3'b100});
    end
    light_new = 1'b1; light_pos = 4'd1; tick();
    light_new = 1'b1; light_pos = 4'd6; tick();
    checks++;
    if (obs !== {6'd1, 6'd1, 6'd0, 2'd3, 3'b010}) begin
      failures++; $display("FAIL sim_double_new got=%h exp=%h", obs, {6'd1, 6'd1, 6'd0, 2'd3, 3'b010});
    end
    key_valid = 1'b1; key = 4'd6; tick();
    checks++;
    if (obs !== {6'd2, 6'd1, 6'd0, 2'd3, 3'b100}) begin
      failures++; $display("FAIL sim_second_target got=%h exp=%h", obs, {6'd2, 6'd1, 6'd0, 2'd3, 3'b100});
    end
    light_new = 1'b1; light_pos = 4'd4; tick();
    key_valid = 1'b1; key = 4'd4; light_new = 1'b1; light_pos = 4'd7; tick();
    key_valid = 1'b1; key = 4'd7; tick();
    checks++;
    if (obs !== {6'd4, 6'd1, 6'd0, 2'd3, 3'b100}) begin
      failures++; $display("FAIL sim_hit_new got=%h exp=%h", obs, {6'd4, 6'd1, 6'd0, 2'd3, 3'b100});
    end
    light_new = 1'b1; light_pos = 4'd8; tick();
    key_valid = 1'b1; key = 4'd0; light_off = 1'b1; tick();
    checks++;
    if (obs !== {6'd4, 6'd2, 6'd1, 2'd3, 3'b010}) begin
      failures++; $display("FAIL sim_wrong_off got=%h exp=%h", obs, {6'd4, 6'd2, 6'd1, 2'd3, 3'b010});
    end
  endtask

  task automatic test_saturation();
    do_start();
    for (int i = 0; i < 64; i++) begin
      light_new = 1'b1; light_pos = 4'd3; tick();
      key_valid = 1'b1; key = 4'd3; tick();
      if (i == 62 || i == 63) begin
        checks++;
        if (obs !== {6'(i + 1 > 63 ? 63 : i + 1), 6'd0, 6'd0, 2'd3, 3'b100}) begin
          failures++; $display("FAIL sat_hit%0d got=%h exp=%h", i + 1, obs, {6'd63, 6'd0, 6'd0, 2'd3, 3'b100});
        end
      end
    end
  endtask

  task automatic test_gating();
    do_start();
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      light_new = 1'($urandom_range(0, 1)); light_pos = 4'($urandom_range(0, 8));
      key_valid = 1'($urandom_range(0, 1)); key = 4'($urandom_range(0, 8));
      light_off = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (obs !== {6'd0, 6'd0, 6'd0, 2'd3, 3'b000}) begin
        failures++; $display("FAIL gate_cycle%0d got=%h exp=%h", i, obs, {6'd0, 6'd0, 6'd0, 2'd3, 3'b000});
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_armed();
    do_start();
    light_new = 1'b1; light_pos = 4'd2; tick();
    key_valid = 1'b1; key = 4'd1; tick();
    checks++;
    if (obs !== {6'd0, 6'd0, 6'd1, 2'd3, 3'b000}) begin
      failures++; $display("FAIL rst_pre got=%h exp=%h", obs, {6'd0, 6'd0, 6'd1, 2'd3, 3'b000});
    end
    #4 reset = 1'b0;
    #2;
    checks++;
    if (obs !== {6'd0, 6'd0, 6'd0, 2'd3, 3'b000}) begin
      failures++; $display("FAIL rst_async got=%h exp=%h", obs, {6'd0, 6'd0, 6'd0, 2'd3, 3'b000});
    end
    #3 reset = 1'b1;
    @(posedge CLOCK_50); #1;
    key_valid = 1'b1; key = 4'd2; tick();
    checks++;
    if (obs !== {6'd0, 6'd0, 6'd1, 2'd3, 3'b000}) begin
      failures++; $display("FAIL rst_window_dropped got=%h exp=%h", obs, {6'd0, 6'd0, 6'd1, 2'd3, 3'b000});
    end
  endtask

  task automatic test_random();
    int ms, mm, mw, ml;
    logic lit, hdone, dead, hp, mp, hit, wp, missed;
    logic [3:0] mt;
    logic [22:0] exp;
    int errs;
    errs = 0;
    do_start();
    ms = 0; mm = 0; mw = 0; ml = 3; lit = 0; hdone = 0; dead = 0; mt = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 59) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) use_lives = ~use_lives;
      light_new = ($urandom_range(0, 5) == 0);
      if (light_new) light_pos = 4'($urandom_range(0, 8));
      light_off = ($urandom_range(0, 5) == 0);
      key_valid = ($urandom_range(0, 2) == 0);
      key = $urandom_range(0, 1) ? mt : 4'($urandom_range(0, 8));
      hp = 0; mp = 0;
      if (start) begin
        ms = 0; mm = 0; mw = 0; ml = 3; lit = 0; hdone = 0; dead = 0;
      end else if (enable && !dead) begin
        hit = lit && !hdone && key_valid && (key == mt);
        wp = key_valid && !hit && !(lit && hdone);
        missed = lit && !hdone && !hit && (light_new || light_off);
        if (hit) begin if (ms < 63) ms++; hp = 1; end
        if (wp && mw < 63) mw++;
        if (missed) begin
          if (mm < 63) mm++;
          mp = 1;
          if (use_lives && ml > 0) begin ml--; if (ml == 0) dead = 1; end
        end
        if (light_new) begin lit = 1; hdone = 0; mt = light_pos; end
        else if (light_off) begin lit = 0; hdone = 0; end
        else if (hit) hdone = 1;
      end
      tick();
      exp = {6'(ms), 6'(mm), 6'(mw), 2'(ml), hp, mp, dead};
      checks++;
      if (obs !== exp) begin
        failures++;
        if (errs < 10) $display("FAIL random_cycle%0d got=%h exp=%h", c, obs, exp);
        errs++;
      end
    end
    enable = 1'b1; use_lives = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit_late_key();
    test_wrong_then_right();
    test_lives();
    test_simultaneous();
    test_saturation();
    test_gating();
    test_reset_armed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
